perceptron_mac: RTL and testbench

- Parametrised, sequential successor of the single-cycle binary perceptron.
- Computes a signed dot product of N_IN multi-bit inputs against a programmable weight memory, plus bias, using one time-shared multiply-accumulate over N_IN cycles.
- Applies a selectable activation and emits a W-bit saturated result.
- Valid/ready on input and output; serves as the neuron primitive for later layer arrays.

---
 rtl/perceptron_pkg.sv | 35 +++
 rtl/perceptron_act.sv | 31 +++
 rtl/perceptron_mac.sv | 159 +++++++++++++++
 tb/tb_perceptron_mac.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types, activation encodings and the saturation helper for the
// perceptron neuron and future layer arrays built from it.
package perceptron_pkg;

   // Controller states: wait for work, accumulate, activate, present result.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      ACT  = 2'b10,
      OUT  = 2'b11
   } state_t;

   // Activation selector encodings; 2'b11 is reserved and behaves as linear.
   localparam logic [1:0] ACT_LIN  = 2'b00;
   localparam logic [1:0] ACT_RELU = 2'b01;
   localparam logic [1:0] ACT_STEP = 2'b10;

   // Clamp a sign-extended accumulator to the signed range of a w-bit value.
   // The caller keeps the low w bits of the result.
   function automatic logic signed [63:0] sat(input logic signed [63:0] acc,
                                              input int                 w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (acc > hi) begin
         return hi;
      end else if (acc < lo) begin
         return lo;
      end else begin
         return acc;
      end
   endfunction

endpackage

// File: rtl/perceptron_act.sv
// Combinational activation stage: maps a wide signed accumulator to a
// W-bit result using linear-saturate, ReLU or step.
module perceptron_act
   import perceptron_pkg::*;
#(
   parameter int W     = 8,
   parameter int ACC_W = 20
) (
   input  logic signed [ACC_W-1:0] i_acc,
   input  logic        [1:0]       i_mode,
   output logic signed [W-1:0]     o_result
);

   logic w_pos;

   // Strictly positive: sign bit clear and not zero.
   assign w_pos = !i_acc[ACC_W-1] && (i_acc != '0);

   // Select the activation; every path assigns the result.
   always_comb begin
      // NOTE: a default assignment up front keeps this purely combinational;
      // any path left unassigned would infer a latch.
      o_result = W'(sat(64'(i_acc), W));
      case (i_mode)
         ACT_RELU: o_result = w_pos ? W'(sat(64'(i_acc), W)) : '0;
         ACT_STEP: o_result = w_pos ? W'(1) : '0;
         default:  ;
      endcase
   end

endmodule

// File: rtl/perceptron_mac.sv
// Sequential perceptron neuron: programmable weights and bias, one shared
// multiply-accumulate over N_IN cycles, then a selectable activation.
module perceptron_mac
   import perceptron_pkg::*;
#(
   parameter int N_IN  = 8,
   parameter int W     = 8,
   parameter int ACC_W = 2 * W + $clog2(N_IN + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [$clog2(N_IN+1)-1:0]  wr_addr,
   input  logic signed [W-1:0]        wr_data,
   output logic                       wr_ready,
   input  logic [1:0]                 act_mode,
   input  logic [N_IN*W-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic signed [W-1:0]        out_data,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int AW = $clog2(N_IN + 1);
   localparam int IW = $clog2(N_IN);
   localparam logic [AW-1:0] BIAS_ADDR = AW'(N_IN);
   localparam logic [IW-1:0] LAST_IDX  = IW'(N_IN - 1);

   state_t                   r_state;
   state_t                   w_next_state;
   logic signed [W-1:0]      r_weights [N_IN];
   logic signed [W-1:0]      r_bias;
   logic [N_IN*W-1:0]        r_x;
   logic [1:0]               r_mode;
   logic signed [ACC_W-1:0]  r_acc;
   logic [IW-1:0]            r_idx;
   logic signed [W-1:0]      r_out_data;
   logic                     r_out_valid;

   logic                     w_wr_fire;
   logic                     w_in_fire;
   logic                     w_out_fire;
   logic                     w_last;
   logic signed [W-1:0]      w_start_bias;
   logic signed [W-1:0]      w_x_cur;
   logic signed [W-1:0]      w_w_cur;
   logic signed [2*W-1:0]    w_prod;
   logic signed [W-1:0]      w_act;

   assign w_wr_fire  = wr_en && wr_ready;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_out_valid && out_ready;
   assign w_last     = (r_idx == LAST_IDX);

   // A bias written in the same cycle as the input handshake seeds the sum.
   assign w_start_bias = (w_wr_fire && (wr_addr == BIAS_ADDR)) ? wr_data : r_bias;

   assign w_x_cur = r_x[int'(r_idx) * W +: W];
   assign w_w_cur = r_weights[r_idx];
   assign w_prod  = w_x_cur * w_w_cur;

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and the IDLE-only ready strobes.
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      wr_ready     = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            wr_ready = 1'b1;
            if (in_valid) w_next_state = ACC;
         end
         ACC:     if (w_last) w_next_state = ACT;
         ACT:     w_next_state = OUT;
         OUT:     if (out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Weight and bias register file; out-of-range addresses are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: this storage is reset on purpose: an abandoned computation must
      // leave all weights and the bias at zero.
      if (!rst_n) begin
         for (int i = 0; i < N_IN; i++) r_weights[i] <= '0;
         r_bias <= '0;
      end else if (w_wr_fire) begin
         if (wr_addr < BIAS_ADDR) begin
            r_weights[wr_addr[IW-1:0]] <= wr_data;
         end else if (wr_addr == BIAS_ADDR) begin
            r_bias <= wr_data;
         end
      end
   end

   // Input capture and the time-shared multiply-accumulate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_mode <= ACT_LIN;
         r_acc  <= '0;
         r_idx  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_in_fire) begin
                  r_x    <= in_data;
                  r_mode <= act_mode;
                  r_acc  <= ACC_W'(w_start_bias);
                  r_idx  <= '0;
               end
            end
            ACC: begin
               r_acc <= r_acc + ACC_W'(w_prod);
               if (!w_last) r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   perceptron_act #(
      .W     (W),
      .ACC_W (ACC_W)
   ) u_act (
      .i_acc    (r_acc),
      .i_mode   (r_mode),
      .o_result (w_act)
   );

   // Output register: load in ACT, hold until the downstream handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else if (r_state == ACT) begin
         r_out_data  <= w_act;
         r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_perceptron_mac.sv
// Scoreboard bench for perceptron_mac: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_perceptron_mac;
   import perceptron_pkg::*;

   localparam int N_IN = 8;
   localparam int W    = 8;
   localparam int AW   = $clog2(N_IN + 1);

   logic                  clk;
   logic                  rst_n;
   logic                  wr_en;
   logic [AW-1:0]         wr_addr;
   logic signed [W-1:0]   wr_data;
   logic                  wr_ready;
   logic [1:0]            act_mode;
   logic [N_IN*W-1:0]     in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic signed [W-1:0]   out_data;
   logic                  out_valid;
   logic                  out_ready;

   typedef struct {
      int    value;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cycle    = 0;
   int   hs_cycle = 0;

   perceptron_mac #(.N_IN(N_IN), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .act_mode  (act_mode),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   // Monitor: every accepted output is compared with the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0d expected no output", out_data);
         end else begin
            e = sb.pop_front();
            check(e.tag, int'(out_data), e.value);
         end
      end
   end

   function automatic logic [N_IN*W-1:0] pack_fill(input int first, input int rest);
      logic [N_IN*W-1:0] r;
      for (int i = 0; i < N_IN; i++) r[i*W +: W] = (i == 0) ? W'(first) : W'(rest);
      return r;
   endfunction

   function automatic logic [N_IN*W-1:0] pack_ramp();
      logic [N_IN*W-1:0] r;
      for (int i = 0; i < N_IN; i++) r[i*W +: W] = W'(i + 1);
      return r;
   endfunction

   task automatic write_reg(input int addr, input int data);
      wr_addr = AW'(addr);
      wr_data = W'(data);
      wr_en   = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic set_weights(input int val, input int bias);
      for (int i = 0; i < N_IN; i++) write_reg(i, val);
      write_reg(N_IN, bias);
   endtask

   // Offer a vector, record the handshake and queue the expected result.
   // Any pending write strobe is released together with in_valid.
   task automatic send(input logic [N_IN*W-1:0] vec, input logic [1:0] mode,
                       input int exp_val, input string tag);
      bit   ok;
      exp_t e;
      in_data  = vec;
      act_mode = mode;
      in_valid = 1'b1;
      ok       = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) begin
         timeout_fail({tag, "_accept"});
      end else begin
         @(posedge clk);
         e.value = exp_val;
         e.tag   = tag;
         sb.push_back(e);
         #1;
         hs_cycle = cycle;
      end
      in_valid = 1'b0;
      wr_en    = 1'b0;
      in_data  = '1;
      act_mode = ACT_STEP;
   endtask

   task automatic wait_valid(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      if (!seen) timeout_fail({tag, "_valid"});
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = (sb.size() == 0) && !out_valid;
      end
      if (!done) timeout_fail({tag, "_drain"});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      act_mode  = ACT_LIN;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_wr_ready", wr_ready, 1);

      // Ramp dot product and handshake-to-valid latency.
      set_weights(1, 0);
      send(pack_ramp(), ACT_LIN, 36, "lin_ramp");
      wait_valid("lin_ramp");
      check("latency", cycle - hs_cycle, N_IN + 1);
      drain("lin_ramp");

      // Writes beyond the bias address leave the bias untouched.
      write_reg(9, 99);
      write_reg(15, -7);
      send(pack_fill(1, 1), ACT_LIN, 8, "oob_write");
      drain("oob_write");

      // Same-cycle write and handshake: new bias and new weight are both used.
      wr_addr = AW'(N_IN);
      wr_data = 8'sd20;
      wr_en   = 1'b1;
      send(pack_fill(1, 1), ACT_LIN, 28, "bias_fwd");
      drain("bias_fwd");
      wr_addr = '0;
      wr_data = 8'sd5;
      wr_en   = 1'b1;
      send(pack_fill(1, 1), ACT_LIN, 32, "weight_fwd");
      drain("weight_fwd");

      // Saturation at both ends; back-to-back vectors through the scoreboard.
      set_weights(127, 127);
      send(pack_fill(127, 127), ACT_LIN, 127, "sat_hi");
      send(pack_fill(-128, -128), ACT_LIN, -128, "sat_lo");
      send(pack_fill(-128, -128), ACT_RELU, 0, "relu_neg_sat");
      send(pack_fill(127, 127), ACT_STEP, 1, "step_big");
      drain("sat");

      // Activations around zero: sum -34, then sum +1.
      set_weights(1, -50);
      send(pack_fill(2, 2), ACT_RELU, 0, "relu_m34");
      send(pack_fill(2, 2), ACT_STEP, 0, "step_m34");
      send(pack_fill(2, 2), ACT_LIN, -34, "lin_m34");
      send(pack_fill(2, 2), 2'b11, -34, "reserved_m34");
      drain("m34");
      write_reg(N_IN, -15);
      send(pack_fill(2, 2), ACT_RELU, 1, "relu_p1");
      send(pack_fill(2, 2), ACT_STEP, 1, "step_p1");
      drain("p1");

      // Back-pressure: result held, competing vector refused.
      out_ready = 1'b0;
      send(pack_fill(2, 2), ACT_LIN, 1, "held");
      wait_valid("held");
      in_data  = pack_fill(3, 3);
      act_mode = ACT_LIN;
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("held_data", int'(out_data), 1);
         check("held_valid", out_valid, 1);
         check("held_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("release_in_ready", in_ready, 1);
      check("release_out_valid", out_valid, 0);
      @(posedge clk);
      #1;

      // Weight write during ACC is dropped for this and the next vector.
      set_weights(1, 0);
      send(pack_fill(1, 0), ACT_LIN, 1, "acc_drop_cur");
      wr_addr = '0;
      wr_data = 8'sd100;
      wr_en   = 1'b1;
      @(negedge clk);
      check("acc_wr_ready", wr_ready, 0);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      drain("acc_drop_cur");
      send(pack_fill(1, 0), ACT_LIN, 1, "acc_drop_next");
      drain("acc_drop_next");

      // Reset in the third ACC cycle abandons the sum and clears the weights.
      set_weights(3, 0);
      send(pack_fill(1, 1), ACT_LIN, 24, "aborted");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_wr_ready", wr_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(pack_fill(5, 5), ACT_LIN, 0, "after_rst");
      drain("after_rst");

      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
